mem_arbiter: RTL

//  Shares the single 32-bit-block main memory between instruction cache (port 0) and data cache (port 1).

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_pick2.sv | 26 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port cache-to-memory arbiter.
// One state enum, port identifiers and the default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  function automatic arb_state_t grant_state(input logic id);
    return (id == PORT_D) ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way pick: a lone requester wins; on a tie the port not served
// last wins when RR=1, otherwise the dcache port wins.
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic vld
);

  assign vld = req0 | req1;

  always_comb begin
    gnt = PORT_I;
    if (req0 && req1) begin
      gnt = RR ? ~last : PORT_D;
    end else if (req1) begin
      gnt = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory between icache (port 0) and dcache (port 1), one access at a time.
// Grant 1 edge after request, then memory latency, then RELEASE+IDLE; losers stall on busywait.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit RR     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_busywait,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_t        state;
  logic              started;
  logic              last;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic              p0_req, p1_req;
  logic              pick_gnt, pick_vld;
  logic              done;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign p0_req = p0_read | p0_write;
  assign p1_req = p1_read | p1_write;
  assign done   = started & ~mem_busywait;

  assign p0_busywait = p0_req & ~((state == GRANT0) & done);
  assign p1_busywait = p1_req & ~((state == GRANT1) & done);

  assign mem_address   = lat_addr;
  assign mem_writedata = lat_data;

  arb_pick2 #(.RR(RR)) u_pick (
    .req0 (p0_req),
    .req1 (p1_req),
    .last (last),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  always_comb begin
    sel_read  = p0_read;
    sel_write = p0_write;
    sel_addr  = p0_address;
    sel_data  = p0_writedata;
    if (pick_gnt == PORT_D) begin
      sel_read  = p1_read;
      sel_write = p1_write;
      sel_addr  = p1_address;
      sel_data  = p1_writedata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      started     <= 1'b0;
      last        <= PORT_D;
      lat_addr    <= '0;
      lat_data    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      p0_readdata <= '0;
      p1_readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= grant_state(pick_gnt);
            lat_addr  <= sel_addr;
            lat_data  <= sel_data;
            // write wins when a port raises both strobes
            mem_write <= sel_write;
            mem_read  <= sel_read & ~sel_write;
          end
        end
        GRANT0, GRANT1: begin
          started <= 1'b1;
          if (done) begin
            if (!mem_write) begin
              if (state == GRANT1) p1_readdata <= mem_readdata;
              else                 p0_readdata <= mem_readdata;
            end
            last      <= (state == GRANT1);
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          started <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
